// File: rtl/ex_stage_pkg.sv
// Shared types for the execute stage: datapath width, ALU and branch
// opcodes, and the EX/MEM register layout.
package ex_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    // funct3 encoding; codes 2 and 3 are unused and never take the branch
    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BLT  = 3'd4,
        BR_BGE  = 3'd5,
        BR_BLTU = 3'd6,
        BR_BGEU = 3'd7
    } br_op_e;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] alu_data;
        logic [XLEN-1:0] store_data;
        logic [3:0]      ld_op;
        logic            mem_wren;
        logic            is_load;
        logic            rd_wren;
        logic [4:0]      rd_addr;
    } exmem_t;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle. master = upstream pipeline/testbench side,
// slave = the execute stage.
interface ex_stage_if;
    import ex_pkg::*;

    logic            enable_i;
    logic [31:0]     instr_i;
    logic [4:0]      rs1_addr_i;
    logic [4:0]      rs2_addr_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] pc_four_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic [XLEN-1:0] imm_i;
    logic            branch_i;
    logic            jump_i;
    logic [3:0]      alu_op_i;
    logic [2:0]      br_op_i;
    logic [3:0]      ld_op_i;
    logic            op_a_sel_i;
    logic            op_b_sel_i;
    logic            mem_wren_i;
    logic            is_load_i;
    logic            rd_wren_i;
    logic [4:0]      rd_addr_i;
    logic [4:0]      wb_rd_addr_i;
    logic            wb_rd_wren_i;
    logic [XLEN-1:0] wb_rd_data_i;

    logic            redirect_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic [31:0]     instr_o;
    logic [XLEN-1:0] alu_data_o;
    logic [XLEN-1:0] store_data_o;
    logic [3:0]      ld_op_o;
    logic            mem_wren_o;
    logic            is_load_o;
    logic            rd_wren_o;
    logic [4:0]      rd_addr_o;

    modport master (
        output enable_i, instr_i, rs1_addr_i, rs2_addr_i, pc_i, pc_four_i,
               rs1_data_i, rs2_data_i, imm_i, branch_i, jump_i, alu_op_i,
               br_op_i, ld_op_i, op_a_sel_i, op_b_sel_i, mem_wren_i,
               is_load_i, rd_wren_i, rd_addr_i, wb_rd_addr_i, wb_rd_wren_i,
               wb_rd_data_i,
        input  redirect_o, redirect_pc_o, instr_o, alu_data_o, store_data_o,
               ld_op_o, mem_wren_o, is_load_o, rd_wren_o, rd_addr_o
    );

    modport slave (
        input  enable_i, instr_i, rs1_addr_i, rs2_addr_i, pc_i, pc_four_i,
               rs1_data_i, rs2_data_i, imm_i, branch_i, jump_i, alu_op_i,
               br_op_i, ld_op_i, op_a_sel_i, op_b_sel_i, mem_wren_i,
               is_load_i, rd_wren_i, rd_addr_i, wb_rd_addr_i, wb_rd_wren_i,
               wb_rd_data_i,
        output redirect_o, redirect_pc_o, instr_o, alu_data_o, store_data_o,
               ld_op_o, mem_wren_o, is_load_o, rd_wren_o, rd_addr_o
    );

endinterface

// File: rtl/ex_stage_alu.sv
// Combinational integer ALU. Shift amount is b_i[4:0]; unknown opcodes give 0.
module alu
    import ex_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  alu_op_e         op_i,
    output logic [XLEN-1:0] res_o
);

    logic [4:0] shamt;

    assign shamt = b_i[4:0];

    // Operation select
    always_comb begin
        res_o = '0;
        case (op_i)
            ALU_ADD:   res_o = a_i + b_i;
            ALU_SUB:   res_o = a_i - b_i;
            ALU_SLL:   res_o = a_i << shamt;
            ALU_SLT:   res_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU:  res_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            ALU_XOR:   res_o = a_i ^ b_i;
            ALU_SRL:   res_o = a_i >> shamt;
            ALU_SRA:   res_o = $signed(a_i) >>> shamt;
            ALU_OR:    res_o = a_i | b_i;
            ALU_AND:   res_o = a_i & b_i;
            ALU_PASSB: res_o = b_i;
            default:   res_o = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding (MEM over WB over regfile), ALU, branch
// resolution, same-cycle PC redirect and the EX/MEM pipeline register.
// Optional build macro EX_PERF_CNT_EN adds redirect and stall counters.
module ex_stage
    import ex_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    ex_stage_if.slave   ex_if
`ifdef EX_PERF_CNT_EN
    ,
    output logic [31:0] redirect_cnt_o,
    output logic [31:0] stall_cnt_o
`endif
);

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic            mem_fwd_ok;
    logic            wb_fwd_ok;
    logic            br_taken;
    logic            redirect;
    exmem_t          exmem_d;
    exmem_t          exmem_q;

    // A load's MEM-stage result is an address, not the loaded data, so it is
    // never a forwarding source; the hazard unit stalls load-use instead.
    assign mem_fwd_ok = exmem_q.rd_wren && (exmem_q.rd_addr != 5'd0) && !exmem_q.is_load;
    assign wb_fwd_ok  = ex_if.wb_rd_wren_i && (ex_if.wb_rd_addr_i != 5'd0);

    // Forwarding mux per source, MEM result has priority over WB
    always_comb begin
        fwd_rs1 = ex_if.rs1_data_i;
        fwd_rs2 = ex_if.rs2_data_i;
        if (mem_fwd_ok && (exmem_q.rd_addr == ex_if.rs1_addr_i)) begin
            fwd_rs1 = exmem_q.alu_data;
        end else if (wb_fwd_ok && (ex_if.wb_rd_addr_i == ex_if.rs1_addr_i)) begin
            fwd_rs1 = ex_if.wb_rd_data_i;
        end
        if (mem_fwd_ok && (exmem_q.rd_addr == ex_if.rs2_addr_i)) begin
            fwd_rs2 = exmem_q.alu_data;
        end else if (wb_fwd_ok && (ex_if.wb_rd_addr_i == ex_if.rs2_addr_i)) begin
            fwd_rs2 = ex_if.wb_rd_data_i;
        end
    end

    assign op_a = ex_if.op_a_sel_i ? ex_if.pc_i  : fwd_rs1;
    assign op_b = ex_if.op_b_sel_i ? ex_if.imm_i : fwd_rs2;

    alu u_alu (
        .a_i   (op_a),
        .b_i   (op_b),
        .op_i  (alu_op_e'(ex_if.alu_op_i)),
        .res_o (alu_res)
    );

    // Branch condition on the forwarded register operands
    always_comb begin
        br_taken = 1'b0;
        case (br_op_e'(ex_if.br_op_i))
            BR_BEQ:  br_taken = (fwd_rs1 == fwd_rs2);
            BR_BNE:  br_taken = (fwd_rs1 != fwd_rs2);
            BR_BLT:  br_taken = ($signed(fwd_rs1) <  $signed(fwd_rs2));
            BR_BGE:  br_taken = ($signed(fwd_rs1) >= $signed(fwd_rs2));
            BR_BLTU: br_taken = (fwd_rs1 <  fwd_rs2);
            BR_BGEU: br_taken = (fwd_rs1 >= fwd_rs2);
            default: br_taken = 1'b0;
        endcase
    end

    // A stalled or resetting stage must not steer fetch
    assign redirect            = ex_if.enable_i && !rst_i &&
                                 (ex_if.jump_i || (ex_if.branch_i && br_taken));
    assign ex_if.redirect_o    = redirect;
    assign ex_if.redirect_pc_o = {alu_res[XLEN-1:1], 1'b0};

    // Next EX/MEM contents: capture when enabled, otherwise hold
    always_comb begin
        exmem_d = exmem_q;
        if (ex_if.enable_i) begin
            exmem_d.instr      = ex_if.instr_i;
            exmem_d.alu_data   = ex_if.jump_i ? ex_if.pc_four_i : alu_res;
            exmem_d.store_data = fwd_rs2;
            exmem_d.ld_op      = ex_if.ld_op_i;
            exmem_d.mem_wren   = ex_if.mem_wren_i;
            exmem_d.is_load    = ex_if.is_load_i;
            exmem_d.rd_wren    = ex_if.rd_wren_i;
            exmem_d.rd_addr    = ex_if.rd_addr_i;
        end
    end

    // EX/MEM register; reset inserts a bubble
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exmem_q <= '0;
        end else begin
            exmem_q <= exmem_d;
        end
    end

    assign ex_if.instr_o      = exmem_q.instr;
    assign ex_if.alu_data_o   = exmem_q.alu_data;
    assign ex_if.store_data_o = exmem_q.store_data;
    assign ex_if.ld_op_o      = exmem_q.ld_op;
    assign ex_if.mem_wren_o   = exmem_q.mem_wren;
    assign ex_if.is_load_o    = exmem_q.is_load;
    assign ex_if.rd_wren_o    = exmem_q.rd_wren;
    assign ex_if.rd_addr_o    = exmem_q.rd_addr;

`ifdef EX_PERF_CNT_EN
    logic [31:0] redirect_cnt_d;
    logic [31:0] redirect_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] stall_cnt_q;

    // Free-running event counters, wrapping naturally at 2^32
    always_comb begin
        redirect_cnt_d = redirect_cnt_q + (redirect ? 32'd1 : 32'd0);
        stall_cnt_d    = stall_cnt_q + (ex_if.enable_i ? 32'd0 : 32'd1);
    end

    // Counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign redirect_cnt_o = redirect_cnt_q;
    assign stall_cnt_o    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage. Stimulus pushes expected results into two
// queues (same-cycle redirect, next-edge EX/MEM contents); monitors pop them
// at the falling edge and just after the rising edge respectively.
module tb_ex_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] store;
        logic [3:0]  ld_op;
        logic        mem_wren;
        logic        is_load;
        logic        rd_wren;
        logic [4:0]  rd;
    } exp_reg_t;

    typedef struct packed {
        logic        redir;
        logic [31:0] pc;
    } exp_cmb_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    exp_reg_t rq[$];
    exp_cmb_t cq[$];
    exp_reg_t last_er;

    ex_stage_if bus();

`ifdef EX_PERF_CNT_EN
    logic [31:0] redirect_cnt;
    logic [31:0] stall_cnt;
`endif

    ex_stage u_dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ex_if          (bus)
`ifdef EX_PERF_CNT_EN
        ,
        .redirect_cnt_o (redirect_cnt),
        .stall_cnt_o    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Same-cycle redirect monitor
    initial begin
        exp_cmb_t e;
        forever begin
            @(negedge clk);
            if (cq.size() > 0) begin
                e = cq.pop_front();
                chk("redirect", {31'd0, bus.redirect_o}, {31'd0, e.redir});
                chk("redirect_pc", bus.redirect_pc_o, e.pc);
            end
        end
    end

    // EX/MEM register monitor
    initial begin
        exp_reg_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rq.size() > 0) begin
                e = rq.pop_front();
                chk("instr", bus.instr_o, e.instr);
                chk("alu_data", bus.alu_data_o, e.alu);
                chk("store_data", bus.store_data_o, e.store);
                chk("ld_op", {28'd0, bus.ld_op_o}, {28'd0, e.ld_op});
                chk("mem_wren", {31'd0, bus.mem_wren_o}, {31'd0, e.mem_wren});
                chk("is_load", {31'd0, bus.is_load_o}, {31'd0, e.is_load});
                chk("rd_wren", {31'd0, bus.rd_wren_o}, {31'd0, e.rd_wren});
                chk("rd_addr", {27'd0, bus.rd_addr_o}, {27'd0, e.rd});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_in();
        bus.enable_i     = 1'b1;
        bus.instr_i      = '0;
        bus.rs1_addr_i   = '0;
        bus.rs2_addr_i   = '0;
        bus.pc_i         = '0;
        bus.pc_four_i    = '0;
        bus.rs1_data_i   = '0;
        bus.rs2_data_i   = '0;
        bus.imm_i        = '0;
        bus.branch_i     = 1'b0;
        bus.jump_i       = 1'b0;
        bus.alu_op_i     = '0;
        bus.br_op_i      = '0;
        bus.ld_op_i      = '0;
        bus.op_a_sel_i   = 1'b0;
        bus.op_b_sel_i   = 1'b0;
        bus.mem_wren_i   = 1'b0;
        bus.is_load_i    = 1'b0;
        bus.rd_wren_i    = 1'b0;
        bus.rd_addr_i    = '0;
        bus.wb_rd_addr_i = '0;
        bus.wb_rd_wren_i = 1'b0;
        bus.wb_rd_data_i = '0;
    endtask

    task automatic set_rs(input logic [4:0] a1, input logic [31:0] d1,
                          input logic [4:0] a2, input logic [31:0] d2);
        bus.rs1_addr_i = a1;
        bus.rs1_data_i = d1;
        bus.rs2_addr_i = a2;
        bus.rs2_data_i = d2;
    endtask

    task automatic set_rd(input logic wren, input logic [4:0] rd);
        bus.rd_wren_i = wren;
        bus.rd_addr_i = rd;
    endtask

    // Queue expectations for the current inputs, then advance one cycle
    task automatic cyc(input logic [31:0] e_alu, input logic [31:0] e_st,
                       input logic e_redir, input logic [31:0] e_pc);
        exp_reg_t er;
        exp_cmb_t ec;
        if (rst) begin
            er = '0;
        end else if (!bus.enable_i) begin
            er = last_er;
        end else begin
            er.instr    = bus.instr_i;
            er.alu      = e_alu;
            er.store    = e_st;
            er.ld_op    = bus.ld_op_i;
            er.mem_wren = bus.mem_wren_i;
            er.is_load  = bus.is_load_i;
            er.rd_wren  = bus.rd_wren_i;
            er.rd       = bus.rd_addr_i;
        end
        last_er  = er;
        ec.redir = e_redir;
        ec.pc    = e_pc;
        rq.push_back(er);
        cq.push_back(ec);
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        last_er = '0;
        rst     = 1'b1;
        clear_in();
        @(posedge clk);
        #2;

        // reset with a jump presented: no redirect, register stays cleared
        clear_in(); bus.instr_i = 32'h1000_0001; bus.jump_i = 1'b1;
        set_rs(5'd0, 32'h20, 5'd0, 32'h0); bus.imm_i = 32'd4; bus.op_b_sel_i = 1'b1;
        cyc(32'h0, 32'h0, 1'b0, 32'h24);
        rst = 1'b0;

        // ADD x5 = 5 + 7
        clear_in(); bus.instr_i = 32'h1000_0002; bus.alu_op_i = 4'd0;
        set_rs(5'd1, 32'd5, 5'd2, 32'd7); set_rd(1'b1, 5'd5);
        cyc(32'd12, 32'd7, 1'b0, 32'd12);

        // x3 = 0x10
        clear_in(); bus.instr_i = 32'h1000_0003;
        set_rs(5'd0, 32'd0, 5'd0, 32'd0); bus.imm_i = 32'h10; bus.op_b_sel_i = 1'b1;
        set_rd(1'b1, 5'd3);
        cyc(32'h10, 32'h0, 1'b0, 32'h10);

        // x4 = x3 + 1 with stale regfile: MEM forward on rs1 and rs2
        clear_in(); bus.instr_i = 32'h1000_0004;
        set_rs(5'd3, 32'd0, 5'd3, 32'd0); bus.imm_i = 32'd1; bus.op_b_sel_i = 1'b1;
        set_rd(1'b1, 5'd4);
        cyc(32'h11, 32'h10, 1'b0, 32'h10);

        // x6 = x3 + 1 with WB-only match
        clear_in(); bus.instr_i = 32'h1000_0005;
        set_rs(5'd3, 32'd0, 5'd0, 32'd0); bus.imm_i = 32'd1; bus.op_b_sel_i = 1'b1;
        bus.wb_rd_wren_i = 1'b1; bus.wb_rd_addr_i = 5'd3; bus.wb_rd_data_i = 32'h10;
        set_rd(1'b1, 5'd6);
        cyc(32'h11, 32'h0, 1'b0, 32'h10);

        // x7 = x6 + 1, MEM (0x11) and WB (0x999) both match: MEM wins
        clear_in(); bus.instr_i = 32'h1000_0006;
        set_rs(5'd6, 32'h55, 5'd0, 32'd0); bus.imm_i = 32'd1; bus.op_b_sel_i = 1'b1;
        bus.wb_rd_wren_i = 1'b1; bus.wb_rd_addr_i = 5'd6; bus.wb_rd_data_i = 32'h999;
        set_rd(1'b1, 5'd7);
        cyc(32'h12, 32'h0, 1'b0, 32'h12);

        // write to x0, then read x0: neither MEM nor WB forwards
        clear_in(); bus.instr_i = 32'h1000_0007;
        bus.imm_i = 32'h77; bus.op_b_sel_i = 1'b1; set_rd(1'b1, 5'd0);
        cyc(32'h77, 32'h0, 1'b0, 32'h76);
        clear_in(); bus.instr_i = 32'h1000_0008;
        set_rs(5'd0, 32'd5, 5'd0, 32'd0); bus.op_b_sel_i = 1'b1;
        bus.wb_rd_wren_i = 1'b1; bus.wb_rd_addr_i = 5'd0; bus.wb_rd_data_i = 32'h999;
        set_rd(1'b1, 5'd8);
        cyc(32'd5, 32'h0, 1'b0, 32'd4);

        // BLT -1 < 1 taken, target pc+imm
        clear_in(); bus.instr_i = 32'h1000_0009; bus.branch_i = 1'b1; bus.br_op_i = 3'd4;
        set_rs(5'd10, 32'hFFFF_FFFF, 5'd11, 32'd1);
        bus.pc_i = 32'h100; bus.imm_i = 32'd8; bus.op_a_sel_i = 1'b1; bus.op_b_sel_i = 1'b1;
        cyc(32'h108, 32'd1, 1'b1, 32'h108);
        // same compare unsigned: not taken
        bus.instr_i = 32'h1000_000A; bus.br_op_i = 3'd6;
        cyc(32'h108, 32'd1, 1'b0, 32'h108);

        // BEQ equal, backward target; then unused code 2 never taken
        clear_in(); bus.instr_i = 32'h1000_000B; bus.branch_i = 1'b1; bus.br_op_i = 3'd0;
        set_rs(5'd13, 32'h33, 5'd14, 32'h33);
        bus.pc_i = 32'h200; bus.imm_i = 32'hFFFF_FFF0; bus.op_a_sel_i = 1'b1; bus.op_b_sel_i = 1'b1;
        cyc(32'h1F0, 32'h33, 1'b1, 32'h1F0);
        bus.instr_i = 32'h1000_000C; bus.br_op_i = 3'd2;
        cyc(32'h1F0, 32'h33, 1'b0, 32'h1F0);

        // JALR rs1=0x203: target bit 0 cleared, link value registered
        clear_in(); bus.instr_i = 32'h1000_000D; bus.jump_i = 1'b1;
        set_rs(5'd12, 32'h203, 5'd0, 32'd0); bus.op_b_sel_i = 1'b1;
        bus.pc_i = 32'h40; bus.pc_four_i = 32'h44; set_rd(1'b1, 5'd1);
        cyc(32'h44, 32'h0, 1'b1, 32'h202);

        // ALU op sweep on register operands
        clear_in(); bus.instr_i = 32'h1000_000E; bus.alu_op_i = 4'd1;
        set_rs(5'd20, 32'd5, 5'd21, 32'd7);
        cyc(32'hFFFF_FFFE, 32'd7, 1'b0, 32'hFFFF_FFFE);
        clear_in(); bus.instr_i = 32'h1000_000F; bus.alu_op_i = 4'd7;
        set_rs(5'd20, 32'h8000_0000, 5'd21, 32'h24);
        cyc(32'hF800_0000, 32'h24, 1'b0, 32'hF800_0000);
        bus.instr_i = 32'h1000_0010; bus.alu_op_i = 4'd6;
        cyc(32'h0800_0000, 32'h24, 1'b0, 32'h0800_0000);
        clear_in(); bus.instr_i = 32'h1000_0011; bus.alu_op_i = 4'd3;
        set_rs(5'd20, 32'hFFFF_FFFF, 5'd21, 32'd1);
        cyc(32'd1, 32'd1, 1'b0, 32'd0);
        bus.instr_i = 32'h1000_0012; bus.alu_op_i = 4'd4;
        cyc(32'd0, 32'd1, 1'b0, 32'd0);
        clear_in(); bus.instr_i = 32'h1000_0013; bus.alu_op_i = 4'd10;
        set_rs(5'd20, 32'h99, 5'd21, 32'h1234);
        cyc(32'h1234, 32'h1234, 1'b0, 32'h1234);
        bus.instr_i = 32'h1000_0014; bus.alu_op_i = 4'd15;
        cyc(32'd0, 32'h1234, 1'b0, 32'd0);
        clear_in(); bus.instr_i = 32'h1000_0015; bus.alu_op_i = 4'd2;
        set_rs(5'd20, 32'd1, 5'd21, 32'h3F);
        cyc(32'h8000_0000, 32'h3F, 1'b0, 32'h8000_0000);

        // load into x9, then a consumer of x9 must not get the load address
        clear_in(); bus.instr_i = 32'h1000_0016; bus.is_load_i = 1'b1; bus.ld_op_i = 4'd2;
        set_rs(5'd20, 32'h1000, 5'd0, 32'd0); bus.imm_i = 32'd4; bus.op_b_sel_i = 1'b1;
        set_rd(1'b1, 5'd9);
        cyc(32'h1004, 32'h0, 1'b0, 32'h1004);
        clear_in(); bus.instr_i = 32'h1000_0017; bus.mem_wren_i = 1'b1;
        set_rs(5'd9, 32'hAB, 5'd22, 32'h5A); bus.op_b_sel_i = 1'b1;
        set_rd(1'b1, 5'd10);
        cyc(32'hAB, 32'h5A, 1'b0, 32'hAA);

        // 3-cycle stall with a jump presented: outputs hold, no redirect,
        // forwarding from the held x10 stays valid
        clear_in(); bus.instr_i = 32'h1000_0018; bus.enable_i = 1'b0; bus.jump_i = 1'b1;
        set_rs(5'd10, 32'd0, 5'd0, 32'd0); bus.imm_i = 32'd1; bus.op_b_sel_i = 1'b1;
        bus.pc_four_i = 32'h99; set_rd(1'b1, 5'd11);
        for (int i = 0; i < 3; i++) begin
            cyc(32'h0, 32'h0, 1'b0, 32'hAC);
        end
`ifdef EX_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, 32'd3);
        chk("redirect_cnt", redirect_cnt, 32'd3);
`endif
        bus.enable_i = 1'b1; bus.jump_i = 1'b0; set_rd(1'b0, 5'd11);
        cyc(32'hAC, 32'h0, 1'b0, 32'hAC);

        // load sitting in the register, then reset mid-operation
        clear_in(); bus.instr_i = 32'h1000_0019; bus.is_load_i = 1'b1; bus.ld_op_i = 4'd4;
        bus.imm_i = 32'h40; bus.op_b_sel_i = 1'b1; set_rd(1'b1, 5'd12);
        cyc(32'h40, 32'h0, 1'b0, 32'h40);
        rst = 1'b1;
        clear_in(); bus.instr_i = 32'h1000_001A; bus.jump_i = 1'b1;
        bus.imm_i = 32'h60; bus.op_b_sel_i = 1'b1; set_rd(1'b1, 5'd13);
        cyc(32'h0, 32'h0, 1'b0, 32'h60);
`ifdef EX_PERF_CNT_EN
        chk("stall_cnt_rst", stall_cnt, 32'd0);
        chk("redirect_cnt_rst", redirect_cnt, 32'd0);
`endif
        rst = 1'b0;
        clear_in();
        cyc(32'h0, 32'h0, 1'b0, 32'h0);

        for (int i = 0; i < 10; i++) begin
            if (rq.size() == 0 && cq.size() == 0) break;
            @(posedge clk);
            #2;
        end
        chk("queues_drained", rq.size() + cq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
